// File: rtl/ntt_ctrl_pkg.sv
// Shared constants and types for the NTT control path.
// Sizes the PE2 sequencer and its write-back bundle.
package ntt_ctrl_pkg;

    localparam int LOGN    = 8;
    localparam int STAGES  = 7;
    localparam int MUL_LAT = 3;
    localparam int RD_LAT  = 1;

    localparam int N  = 1 << LOGN;
    localparam int AW = LOGN;
    localparam int JW = LOGN - 1;
    localparam int D  = RD_LAT + MUL_LAT + 2;
    localparam int DW = $clog2(D);
    localparam int SW = $clog2(LOGN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] u;
        logic [AW-1:0] v;
    } wb_t;

endpackage

// File: rtl/pe2_ctrl_delay.sv
// Fixed-depth shift register with asynchronous clear.
// Aligns read-side strobes with PE2 write-back.
module ctrl_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] pipe;

    // shift one slot per cycle; reset flushes every slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/pe2_ctrl.sv
// PE2 stage sequencer: walks stages and butterflies,
// generates read/twiddle addresses and aligned writes.
module pe2_ctrl
    import ntt_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [2:0]    stage,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_u,
    output logic [AW-1:0] rd_addr_v,
    output logic [AW-1:0] tw_addr1,
    output logic [AW-1:0] tw_addr2,
    output logic          sel,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_lo,
    output logic [AW-1:0] wr_addr_up
);

    ctrl_state_t   state_q, state_d;
    logic [JW-1:0] j_q;
    logic [DW-1:0] dcnt_q;
    logic [2:0]    s_q;
    logic          mode_q;

    logic j_last, d_last, s_last;

    assign j_last = (j_q == JW'(N/2 - 1));
    assign d_last = (dcnt_q == DW'(D - 1));
    assign s_last = mode_q ? (s_q == 3'd0)
                           : (s_q == 3'(STAGES - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // next-state: run a stage, drain, repeat, then done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)  state_d = ST_RUN;
            ST_RUN:   if (j_last) state_d = ST_DRAIN;
            ST_DRAIN: if (d_last)
                state_d = s_last ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // butterfly, drain and stage counters; mode latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q    <= '0;
            dcnt_q <= '0;
            s_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) begin
                    mode_q <= mode;
                    s_q    <= mode ? 3'(STAGES - 1) : 3'd0;
                    j_q    <= '0;
                    dcnt_q <= '0;
                end
                ST_RUN: begin
                    if (j_last) begin
                        j_q    <= '0;
                        dcnt_q <= '0;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (d_last) begin
                        dcnt_q <= '0;
                        if (!s_last)
                            s_q <= mode_q ? s_q - 3'd1
                                          : s_q + 3'd1;
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // h = 1<<sh, g = j>>sh, k = j mod h
    logic [SW-1:0] sh;
    logic [AW-1:0] j_ext, half, g, k;
    logic [AW-1:0] u_a, v_a, t, tw1;

    // address generation for the current butterfly
    always_comb begin
        sh    = SW'(LOGN - 1) - SW'(s_q);
        j_ext = AW'(j_q);
        half  = AW'(1) << sh;
        g     = j_ext >> sh;
        k     = j_ext & (half - AW'(1));
        u_a   = (g << (sh + SW'(1))) | k;
        v_a   = u_a + half;
        t     = (AW'(1) << s_q) + g;
        tw1   = t << 1;
    end

    assign rd_en     = (state_q == ST_RUN);
    assign busy      = rd_en || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign stage     = busy ? s_q : 3'd0;
    assign sel       = busy & mode_q;
    assign rd_addr_u = rd_en ? u_a : '0;
    assign rd_addr_v = rd_en ? v_a : '0;
    assign tw_addr1  = rd_en ? tw1 : '0;
    assign tw_addr2  = rd_en ? (tw1 | AW'(1)) : '0;

    wb_t wb_in, wb_out;

    assign wb_in = '{en: rd_en,
                     u:  rd_addr_u,
                     v:  rd_addr_v};

    ctrl_delay #(
        .W     ($bits(wb_t)),
        .DEPTH (D)
    ) u_wb_dly (
        .clk (clk),
        .rst (rst),
        .d   (wb_in),
        .q   (wb_out)
    );

    assign wr_en      = wb_out.en;
    assign wr_addr_lo = wb_out.u;
    assign wr_addr_up = wb_out.v;

endmodule

// File: tb/tb_pe2_ctrl.sv
// Scoreboard bench for pe2_ctrl: a pass-level model
// queues expected reads, writes and done; monitor checks.
module tb_pe2_ctrl;

    localparam int TN  = 256;
    localparam int TST = 7;
    localparam int TD  = 6;
    localparam int SPAN = TN/2 + TD;

    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic       busy, done, sel, rd_en, wr_en;
    logic [2:0] stage;
    logic [7:0] rd_addr_u, rd_addr_v;
    logic [7:0] tw_addr1, tw_addr2;
    logic [7:0] wr_addr_lo, wr_addr_up;

    pe2_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .stage      (stage),
        .rd_en      (rd_en),
        .rd_addr_u  (rd_addr_u),
        .rd_addr_v  (rd_addr_v),
        .tw_addr1   (tw_addr1),
        .tw_addr2   (tw_addr2),
        .sel        (sel),
        .wr_en      (wr_en),
        .wr_addr_lo (wr_addr_lo),
        .wr_addr_up (wr_addr_up)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cyc;
        int u, v, t1, t2, s, j, p;
    } rd_t;

    typedef struct {
        longint cyc;
        int u, v;
    } wr_t;

    rd_t    rd_q[$];
    wr_t    wr_q[$];
    longint done_q[$];

    longint cyc = 0;
    longint cur_a = -100000;
    longint last_wr = -1;
    bit     cur_m = 0;
    bit     active = 0;
    bit     mon_en = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // pass-level model: every read, write and done time
    task automatic push_pass(input longint a, input bit m);
        int s, h, g, k, t;
        rd_t r;
        wr_t w;
        for (int p = 0; p < TST; p++) begin
            s = m ? TST - 1 - p : p;
            h = TN >> (s + 1);
            for (int j = 0; j < TN/2; j++) begin
                g = j / h;
                k = j % h;
                t = (1 << s) + g;
                r.cyc = a + p*SPAN + j;
                r.u = 2*h*g + k;
                r.v = r.u + h;
                r.t1 = 2*t;
                r.t2 = 2*t + 1;
                r.s = s;
                r.j = j;
                r.p = p;
                rd_q.push_back(r);
                w.cyc = r.cyc + TD;
                w.u = r.u;
                w.v = r.v;
                wr_q.push_back(w);
            end
        end
        done_q.push_back(a + TST*SPAN);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_u"}, rd_addr_u, 0);
        chk({tag, "_v"}, rd_addr_v, 0);
        chk({tag, "_tw1"}, tw_addr1, 0);
        chk({tag, "_tw2"}, tw_addr2, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_lo"}, wr_addr_lo, 0);
        chk({tag, "_up"}, wr_addr_up, 0);
    endtask

    task automatic issue_start(input bit m);
        mode = m;
        start = 1'b1;
        cur_a = cyc + 1;
        cur_m = m;
        active = 1'b1;
        push_pass(cur_a, m);
        step();
        start = 1'b0;
    endtask

    // monitor: pop and compare whenever the DUT presents
    always @(negedge clk) begin
        rd_t    r;
        wr_t    w;
        longint dt;
        bit     eb;
        if (!rst && mon_en) begin
            eb = active && cyc >= cur_a
                 && cyc <= cur_a + TST*SPAN - 1;
            chk("busy", busy, eb);
            chk("sel", sel, eb ? cur_m : 1'b0);
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_cyc", cyc, w.cyc);
                    chk("wr_lo", wr_addr_lo, w.u);
                    chk("wr_up", wr_addr_up, w.v);
                    if (!cur_m && cyc - cur_a + 1 == 7) begin
                        chk("first_wr_lo", wr_addr_lo, 0);
                        chk("first_wr_up", wr_addr_up, 128);
                    end
                end
                last_wr = cyc;
            end else if (wr_q.size() > 0
                         && wr_q[0].cyc <= cyc) begin
                chk("wr_missing", 0, 1);
                void'(wr_q.pop_front());
            end
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_cyc", cyc, r.cyc);
                    chk("rd_u", rd_addr_u, r.u);
                    chk("rd_v", rd_addr_v, r.v);
                    chk("tw1", tw_addr1, r.t1);
                    chk("tw2", tw_addr2, r.t2);
                    chk("stage", stage, r.s);
                    if (r.j == 0 && r.p > 0)
                        chk("hazard_gap", last_wr, cyc - 1);
                    if (r.s == 0 && r.j == 0) begin
                        chk("s0j0_u", rd_addr_u, 0);
                        chk("s0j0_v", rd_addr_v, 128);
                        chk("s0j0_tw1", tw_addr1, 2);
                        chk("s0j0_tw2", tw_addr2, 3);
                    end
                    if (r.s == 0 && r.j == 127) begin
                        chk("s0j127_u", rd_addr_u, 127);
                        chk("s0j127_v", rd_addr_v, 255);
                    end
                    if (r.s == 6 && r.j == 0) begin
                        chk("s6j0_u", rd_addr_u, 0);
                        chk("s6j0_v", rd_addr_v, 2);
                        chk("s6j0_tw1", tw_addr1, 128);
                        chk("s6j0_tw2", tw_addr2, 129);
                    end
                    if (r.s == 6 && r.j == 2) begin
                        chk("s6j2_u", rd_addr_u, 4);
                        chk("s6j2_v", rd_addr_v, 6);
                        chk("s6j2_tw1", tw_addr1, 130);
                    end
                end
            end else if (rd_q.size() > 0
                         && rd_q[0].cyc <= cyc) begin
                chk("rd_missing", 0, 1);
                void'(rd_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    dt = done_q.pop_front();
                    chk("done_cyc", cyc, dt);
                    chk("done_rel", cyc - cur_a + 1, 939);
                end
            end else if (done_q.size() > 0
                         && done_q[0] <= cyc) begin
                chk("done_missing", 0, 1);
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        repeat (3) step();
        check_zero("rst");
        rst = 1'b0;
        step();
        check_zero("idle");
        mon_en = 1'b1;

        // abort a pass in its 50th cycle
        issue_start(1'b0);
        while (cyc < cur_a + 49) step();
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        active = 1'b0;
        #1;
        check_zero("midrst");
        step();
        step();
        rst = 1'b0;
        repeat (20) begin
            step();
            chk("post_rst_wr", wr_en, 0);
            chk("post_rst_rd", rd_en, 0);
        end

        for (int p = 0; p < 6; p++) begin
            if (p == 0)      issue_start(1'b0);
            else if (p == 1) issue_start(1'b1);
            else             issue_start(1'($urandom % 2));
            while (cyc < cur_a + TST*SPAN) begin
                start = ($urandom % 6) == 0;
                mode = 1'($urandom % 2);
                step();
            end
            start = (p == 0) || (($urandom % 2) == 0);
            mode = 1'($urandom % 2);
            step();
            start = 1'b0;
            if (p != 0) repeat ($urandom % 3) step();
        end

        start = 1'b0;
        repeat (12) step();
        chk("leftover",
            rd_q.size() + wr_q.size() + done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe2_ctrl.md
# pe2_ctrl

Stage sequencer for the PE2 butterfly in the mixed-radix NTT core. For each NTT/INTT pass it walks every stage and butterfly of an N-point polynomial, issuing one butterfly per cycle. Per butterfly it generates the coefficient-memory read addresses (u, v), the twiddle-ROM addresses (w1, w2) and PE2's `sel`. It delays write-back addresses and enables so they line up with PE2's `bf_lower`/`bf_upper` outputs, and it drains the pipeline between stages so no read precedes an outstanding write.

## Interface
- `LOGN`, 8, log2 of the polynomial length N (N = 256).
- `STAGES`, 7, number of butterfly stages per pass; STAGES ≤ LOGN-1.
- `MUL_LAT`, 3, modular_mul latency in cycles.
- `RD_LAT`, 1, coefficient-memory read latency in cycles.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a pass; honoured only in IDLE.
- `mode` in 1: 0 = NTT, 1 = INTT; latched when `start` is accepted.
- `busy` out 1: high from the accept edge through the end of the last drain.
- `done` out 1: one-cycle pulse when the pass completes.
- `stage` out 3: index of the current stage.
- `rd_en` out 1: read strobe for the u/v memory ports.
- `rd_addr_u`, `rd_addr_v` out LOGN: read addresses for u and v.
- `tw_addr1`, `tw_addr2` out LOGN: twiddle-ROM addresses for w1 and w2.
- `sel` out 1: drives PE2 `sel`; equals the latched mode while `busy`, 0 otherwise.
- `wr_en` out 1: write strobe for both write ports.
- `wr_addr_lo` out LOGN: write address for `bf_lower`.
- `wr_addr_up` out LOGN: write address for `bf_upper`.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE → RUN when `start` is sampled high. RUN issues butterfly j = 0..N/2-1, one per cycle.
- RUN → DRAIN after j = N/2-1. DRAIN lasts exactly D = RD_LAT+MUL_LAT+2 cycles.
- DRAIN → RUN for the next stage with j = 0, or → DONE after the final stage. DONE → IDLE after one cycle.
- Stage order: NTT runs s = 0..STAGES-1; INTT runs s = STAGES-1..0. `stage` shows the current s.
- Address arithmetic for stage s:
  - half-span h = N>>(s+1); group g = j / h; k = j mod h.
  - `rd_addr_u` = 2·h·g + k; `rd_addr_v` = `rd_addr_u` + h.
  - Twiddle index t = (1<<s) + g; `tw_addr1` = 2t; `tw_addr2` = 2t+1.
  - All arithmetic is unsigned; no wrap can occur within the parameter constraint.
- `rd_en`, `rd_addr_u` and `rd_addr_v` enter a D-deep delay line. Its output drives `wr_en`, `wr_addr_lo` (= the delayed u address) and `wr_addr_up` (= the delayed v address).
- `start` while busy is ignored; `mode` is not resampled mid-pass.

## Timing
- Reset: state IDLE, j = 0, all outputs 0, delay line cleared. A reset mid-pass aborts the pass with no further `wr_en`.
- Cycle numbering: the accept edge is cycle 0.
  - The first `rd_en` is in cycle 1.
  - The read in cycle c produces `wr_en` in cycle c+D.
  - Each stage occupies N/2 + D cycles.
- The last write of a stage lands one cycle before the next stage's first read. The memory needs no read-during-write bypass.
- `done` is high in cycle STAGES·(N/2+D)+1, which is 939 for the defaults (D = 6). `busy` falls in that same cycle.
- `start` presented in the DONE cycle is ignored. `start` presented in the following IDLE cycle is accepted.

## Structure
- The shared package `ntt_ctrl_pkg` holds the FSM state enum and the localparams N, D and the address width. PE2-side parameters are reused from it.
- One sub-module, `ctrl_delay`: a parameterised D-stage shift register with asynchronous clear. It is instantiated once for the {`rd_en`, `rd_addr_u`, `rd_addr_v`} bundle.
- Counters (j, stage, drain) and the address generation live in `pe2_ctrl`.

## Test plan
- Reset mid-RUN (cycle 50), then release: all outputs read 0; `wr_en` stays 0 for 20 cycles afterwards; the next `start` gives a full pass of 939 cycles.
- NTT, stage 0:
  - j=0 gives u=0, v=128, tw1=2, tw2=3.
  - j=127 gives u=127, v=255.
  - `wr_en` for j=0 appears in cycle 7 with `wr_addr_lo`=0, `wr_addr_up`=128.
- NTT, stage 6:
  - j=0 gives u=0, v=2, tw1=128, tw2=129.
  - j=2 gives u=4, v=6, tw1=130.
- INTT pass: `stage` sequence 6→0; `sel`=1 throughout `busy`; stage-0 addresses match the NTT stage-0 addresses.
- Hazard check: within each stage, the last `wr_en` cycle is exactly one cycle before the next stage's first `rd_en`.
- `start` pulsed while busy and in the DONE cycle: ignored. `done` is a single pulse at cycle 939; `start` in the following cycle begins a new pass.
